// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encodings and default widths for the program-counter sequencer
package pc_seq_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int CNT_W_DEF  = 8;

    // Encodings 6 and 7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/pc_next_addr.sv
// rtl/pc_next_addr.sv - combinational next-instruction-address select (jump > branch > increment)
module pc_next_addr
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] next_addr
);

    // Adding the ADDR_W-bit offset modulo 2**ADDR_W is the same as adding it sign-extended.
    always_comb begin
        next_addr = read_addr + ADDR_W'(1);
        if (jump) begin
            next_addr = target;
        end else if (branch && zero_flag) begin
            next_addr = read_addr + target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - FETCH/DECODE/EXEC/WB sequencer owning the instruction address and retire counter
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] read_addr,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              exec_en,
    output logic              wb_en,
    output logic              halted,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;
    logic [CNT_W-1:0]  retired_q;

    pc_next_addr #(
        .ADDR_W(ADDR_W)
    ) u_next_addr (
        .read_addr(addr_q),
        .jump     (jump),
        .branch   (branch),
        .zero_flag(zero_flag),
        .target   (target),
        .next_addr(addr_next)
    );

    // State register; falling edge to line up with instruction-address timing.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; stall only matters in FETCH and EXEC, halt_req only in DECODE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = start ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_d = stall ? ST_FETCH : ST_DECODE;
            ST_DECODE: state_d = halt_req ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = stall ? ST_EXEC : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = start ? ST_FETCH : ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Address and retire counter advance only on the WB -> FETCH edge; the counter saturates.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            retired_q <= '0;
        end else if (state_q == ST_WB) begin
            addr_q <= addr_next;
            if (retired_q != {CNT_W{1'b1}}) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign read_addr = addr_q;
    assign retired   = retired_q;
    assign state     = state_q;
    assign fetch_en  = (state_q == ST_FETCH);
    assign decode_en = (state_q == ST_DECODE);
    assign exec_en   = (state_q == ST_EXEC);
    assign wb_en     = (state_q == ST_WB);
    assign halted    = (state_q == ST_HALT);

endmodule
